mul16_shift_add: RTL

- Sequential 16x16 unsigned multiplier built on a single 16-bit ripple-carry add per cycle, using the shift-add algorithm.
- Sits directly upstream of the 16-bit adder. Each cycle it supplies the adder's two 16-bit operands and consumes the 16-bit sum and carry-out.
- Produces a 32-bit product after 16 iterations, with a start/busy/done handshake toward the controlling datapath.

---
 rtl/mul16_shift_add.sv | 78 +++++++
 1 files changed

// File: rtl/mul16_shift_add.sv
// Sequential 16x16 unsigned shift-add multiplier: one 16-bit add per clock,
// 32-bit product after 16 iterations, with a start/busy/done handshake.
module mul16_shift_add (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_A,
  input  logic [15:0] i_B,
  output logic [31:0] o_P,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] m, acc, q;
  logic [3:0]  cnt;
  logic [15:0] add_y;
  logic [16:0] sum;

  // Single 16-bit add with carry-out; carry-in is always zero.
  function automatic logic [16:0] add16(input logic [15:0] x, input logic [15:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  always_comb begin
    add_y = q[0] ? m : 16'h0000;
    sum   = add16(acc, add_y);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (cnt == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Carry-out lands in ACC[15] so the full 33-bit shift keeps the top bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m   <= '0;
      acc <= '0;
      q   <= '0;
      cnt <= '0;
      o_P <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            m   <= i_A;
            q   <= i_B;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          {acc, q} <= {sum, q[15:1]};
          cnt      <= cnt + 4'd1;
          if (cnt == 4'd15) o_P <= {sum, q[15:1]};
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);

endmodule
